// File: rtl/coef_demux_loader_16b.sv
`default_nettype none
// ============================================================================
// Module      : coef_demux_loader_16b
// Description : Serial-to-parallel coefficient loader. A valid/ready stream of
//               16-bit words is distributed across NTAPS coefficient
//               registers by an internal tap counter; a one-cycle done pulse
//               marks the end of a complete coefficient set.
// Revision    : 1.0 - initial release
// ============================================================================
module coef_demux_loader_16b #(
   parameter int NTAPS = 8,
   parameter int IDXW  = 3,
   parameter int W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [W-1:0]         in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [NTAPS*W-1:0]   coef_flat,
   output logic [IDXW-1:0]      load_idx,
   output logic                 busy,
   output logic                 done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Index of the final tap; the counter wraps here explicitly so that
   // non-power-of-two tap counts never run past the last register.
   localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NTAPS - 1);

   logic [1:0]      state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [W-1:0]    coef_q [NTAPS];

   // in_ready is decoded from state alone, so accept depends only on
   // registered state and in_valid.
   logic w_accept;
   logic w_last;

   assign w_accept = in_valid & (state_q == S_LOAD);
   assign w_last   = (idx_q == C_LAST_IDX);
   assign load_idx = idx_q;

   // State and tap-counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state and next-index logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               idx_d   = '0;
            end
         end
         S_LOAD: begin
            if (w_accept) begin
               if (w_last) begin
                  idx_d   = '0;
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Status outputs decoded purely from the current state.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         S_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   // One register per tap; reset clears every tap so a partial set never
   // survives a reset, otherwise untouched taps retain their value.
   generate
      for (genvar k = 0; k < NTAPS; k++) begin : g_coef
         // Capture the incoming word when this tap is the current target.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               coef_q[k] <= '0;
            end else if (w_accept && (idx_q == IDXW'(k))) begin
               coef_q[k] <= in_data;
            end
         end
         assign coef_flat[k*W +: W] = coef_q[k];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_coef_demux_loader_16b.sv
`default_nettype none
// ============================================================================
// Module      : tb_coef_demux_loader_16b
// Description : Self-checking bench for coef_demux_loader_16b using a
//               behavioural model of the load protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coef_demux_loader_16b;

   localparam int NTAPS = 8;
   localparam int IDXW  = 3;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  start;
   logic [15:0]           in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [NTAPS*16-1:0]   coef_flat;
   logic [IDXW-1:0]       load_idx;
   logic                  busy;
   logic                  done;

   int errors = 0;
   int checks = 0;

   // Behavioural model: coefficient array, whether a load is in progress,
   // the slot the next word goes to, and whether a completion is being flagged.
   logic [15:0] m_coef [NTAPS];
   bit          m_loading;
   bit          m_done;
   int          m_next;

   coef_demux_loader_16b #(.NTAPS(NTAPS), .IDXW(IDXW), .W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .coef_flat (coef_flat),
      .load_idx  (load_idx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   function automatic logic [NTAPS*16-1:0] model_flat();
      logic [NTAPS*16-1:0] f;
      for (int k = 0; k < NTAPS; k++) f[k*16 +: 16] = m_coef[k];
      return f;
   endfunction

   // Drive one cycle of inputs, advance the model at the edge, settle.
   task automatic cyc(input logic st, input logic v, input logic [15:0] d, input logic rn);
      @(negedge clk);
      start = st; in_valid = v; in_data = d; rst_n = rn;
      @(posedge clk);
      if (!rn) begin
         for (int k = 0; k < NTAPS; k++) m_coef[k] = 16'h0000;
         m_loading = 0; m_done = 0; m_next = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_loading) begin
         if (v) begin
            m_coef[m_next] = d;
            if (m_next == NTAPS - 1) begin
               m_next = 0; m_loading = 0; m_done = 1;
            end else begin
               m_next = m_next + 1;
            end
         end
      end else if (st) begin
         m_loading = 1; m_next = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      cyc(1'b1, 1'b1, 16'(($urandom)), 1'b0);
      cyc(1'b0, 1'b1, 16'(($urandom)), 1'b0);
      checks++;
      if (coef_flat !== '0 || load_idx !== 3'd0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset: coef=%h idx=%0d rdy=%b busy=%b done=%b required all zero", coef_flat, load_idx, in_ready, busy, done);
      end
      cyc(1'b0, 1'b1, 16'h5555, 1'b1);
      checks++;
      if (in_ready !== 1'b0 || coef_flat !== '0) begin
         errors++;
         $display("FAIL idle_ignores_valid: rdy=%b coef=%h required rdy=0 coef=0", in_ready, coef_flat);
      end
   endtask

   task automatic test_sequential();
      int done_cnt = 0;
      cyc(1'b1, 1'b0, 16'h0, 1'b1);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1 || load_idx !== 3'd0) begin
         errors++;
         $display("FAIL seq_enter_load: busy=%b rdy=%b idx=%0d required 1 1 0", busy, in_ready, load_idx);
      end
      for (int i = 0; i < NTAPS; i++) begin
         cyc(1'b0, 1'b1, 16'(i + 1), 1'b1);
         if (done === 1'b1) done_cnt++;
         checks++;
         if (coef_flat !== model_flat() || load_idx !== IDXW'(m_next) || in_ready !== m_loading || done !== m_done) begin
            errors++;
            $display("FAIL seq_step%0d: coef=%h idx=%0d rdy=%b done=%b required coef=%h idx=%0d rdy=%b done=%b",
                     i, coef_flat, load_idx, in_ready, done, model_flat(), m_next, m_loading, m_done);
         end
      end
      for (int k = 0; k < NTAPS; k++) begin
         checks++;
         if (coef_flat[k*16 +: 16] !== 16'(k + 1)) begin
            errors++;
            $display("FAIL seq_slot%0d: got %h required %h", k, coef_flat[k*16 +: 16], 16'(k + 1));
         end
      end
      cyc(1'b0, 1'b1, 16'hDEAD, 1'b1);
      if (done === 1'b1) done_cnt++;
      cyc(1'b0, 1'b0, 16'h0, 1'b1);
      if (done === 1'b1) done_cnt++;
      checks++;
      if (done_cnt != 1 || in_ready !== 1'b0 || busy !== 1'b0 || coef_flat !== model_flat()) begin
         errors++;
         $display("FAIL seq_done_once: pulses=%0d rdy=%b busy=%b required pulses=1 rdy=0 busy=0", done_cnt, in_ready, busy);
      end
   endtask

   task automatic test_toggle();
      int acc = 0;
      int n = 0;
      cyc(1'b1, 1'b0, 16'h0, 1'b1);
      while (acc < NTAPS && n < 40) begin
         logic v;
         v = (n % 2 == 0);
         cyc(1'b0, v, v ? 16'(acc + 1) : 16'hBEEF, 1'b1);
         if (v) acc++;
         n++;
         checks++;
         if (coef_flat !== model_flat() || load_idx !== IDXW'(m_next) || done !== m_done || busy !== m_loading) begin
            errors++;
            $display("FAIL toggle_cyc%0d: coef=%h idx=%0d done=%b busy=%b required coef=%h idx=%0d done=%b busy=%b",
                     n, coef_flat, load_idx, done, busy, model_flat(), m_next, m_done, m_loading);
         end
      end
      checks++;
      if (done !== 1'b1 || acc != NTAPS) begin
         errors++;
         $display("FAIL toggle_done: done=%b accepts=%0d required done=1 accepts=%0d", done, acc, NTAPS);
      end
      cyc(1'b0, 1'b0, 16'h0, 1'b1);
   endtask

   task automatic test_patterns();
      logic [15:0] pat [NTAPS];
      pat[0] = 16'hFFFF; pat[1] = 16'h8000; pat[2] = 16'h7FFF; pat[3] = 16'h0000;
      pat[4] = 16'h1234; pat[5] = 16'hABCD; pat[6] = 16'h00FF; pat[7] = 16'hFF00;
      cyc(1'b1, 1'b0, 16'h0, 1'b1);
      for (int i = 0; i < NTAPS; i++) cyc(1'b0, 1'b1, pat[i], 1'b1);
      for (int k = 0; k < NTAPS; k++) begin
         checks++;
         if (coef_flat[k*16 +: 16] !== pat[k]) begin
            errors++;
            $display("FAIL pattern_slot%0d: got %h required %h", k, coef_flat[k*16 +: 16], pat[k]);
         end
      end
      cyc(1'b0, 1'b0, 16'h0, 1'b1);
   endtask

   task automatic test_mid_reset();
      int done_cnt = 0;
      cyc(1'b1, 1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'($urandom), 1'b1);
      cyc(1'b0, 1'b1, 16'h7777, 1'b0);
      checks++;
      if (coef_flat !== '0 || load_idx !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: coef=%h idx=%0d busy=%b rdy=%b done=%b required all zero", coef_flat, load_idx, busy, in_ready, done);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 16'h1111, 1'b1);
         if (done === 1'b1) done_cnt++;
      end
      checks++;
      if (done_cnt != 0 || coef_flat !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_after: pulses=%0d coef=%h busy=%b required 0 0 0", done_cnt, coef_flat, busy);
      end
   endtask

   task automatic test_start_held();
      int done_cnt = 0;
      cyc(1'b1, 1'b0, 16'h0, 1'b1);
      for (int i = 0; i < NTAPS; i++) begin
         cyc(1'b1, 1'b1, 16'(16'hA000 + i), 1'b1);
         if (done === 1'b1) done_cnt++;
         checks++;
         if (load_idx !== IDXW'(m_next) || busy !== m_loading || done !== m_done) begin
            errors++;
            $display("FAIL start_held_step%0d: idx=%0d busy=%b done=%b required idx=%0d busy=%b done=%b",
                     i, load_idx, busy, done, m_next, m_loading, m_done);
         end
      end
      cyc(1'b1, 1'b1, 16'h0, 1'b1);
      if (done === 1'b1) done_cnt++;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || done_cnt != 1) begin
         errors++;
         $display("FAIL start_held_idle: busy=%b rdy=%b pulses=%0d required busy=0 rdy=0 pulses=1", busy, in_ready, done_cnt);
      end
      cyc(1'b1, 1'b0, 16'h0, 1'b1);
      checks++;
      if (busy !== 1'b1 || load_idx !== 3'd0) begin
         errors++;
         $display("FAIL start_held_restart: busy=%b idx=%0d required busy=1 idx=0", busy, load_idx);
      end
      for (int i = 0; i < NTAPS; i++) cyc(1'b0, 1'b1, 16'(16'hB000 + i), 1'b1);
      cyc(1'b0, 1'b0, 16'h0, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [15:0] a [NTAPS];
      logic [15:0] b [NTAPS];
      for (int k = 0; k < NTAPS; k++) begin
         a[k] = 16'($urandom);
         b[k] = 16'($urandom);
      end
      cyc(1'b1, 1'b0, 16'h0, 1'b1);
      for (int i = 0; i < NTAPS; i++) cyc(1'b0, 1'b1, a[i], 1'b1);
      cyc(1'b0, 1'b0, 16'h0, 1'b1);
      cyc(1'b1, 1'b0, 16'h0, 1'b1);
      for (int k = 0; k < NTAPS; k++) begin
         checks++;
         if (coef_flat[k*16 +: 16] !== a[k]) begin
            errors++;
            $display("FAIL b2b_setA_slot%0d: got %h required %h", k, coef_flat[k*16 +: 16], a[k]);
         end
      end
      for (int i = 0; i < NTAPS; i++) begin
         cyc(1'b0, 1'b1, b[i], 1'b1);
         checks++;
         if (coef_flat !== model_flat()) begin
            errors++;
            $display("FAIL b2b_partial%0d: got %h required %h", i, coef_flat, model_flat());
         end
      end
      for (int k = 0; k < NTAPS; k++) begin
         checks++;
         if (coef_flat[k*16 +: 16] !== b[k]) begin
            errors++;
            $display("FAIL b2b_setB_slot%0d: got %h required %h", k, coef_flat[k*16 +: 16], b[k]);
         end
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done: got %b required 1", done);
      end
      cyc(1'b0, 1'b0, 16'h0, 1'b1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         logic st, v, rn;
         st = ($urandom_range(0, 3) == 0);
         v  = ($urandom_range(0, 2) != 0);
         rn = ($urandom_range(0, 60) != 0);
         cyc(st, v, 16'($urandom), rn);
         checks++;
         if (coef_flat !== model_flat() || load_idx !== IDXW'(m_next) || in_ready !== m_loading ||
             busy !== m_loading || done !== m_done) begin
            errors++;
            $display("FAIL random_cyc%0d: coef=%h idx=%0d rdy=%b busy=%b done=%b required coef=%h idx=%0d rdy=%b busy=%b done=%b",
                     n, coef_flat, load_idx, in_ready, busy, done, model_flat(), m_next, m_loading, m_loading, m_done);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 16'h0;
      for (int k = 0; k < NTAPS; k++) m_coef[k] = 16'h0;
      m_loading = 0; m_done = 0; m_next = 0;
      test_reset();
      test_sequential();
      test_toggle();
      test_patterns();
      test_mid_reset();
      test_start_held();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
